// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the pipeline, register file and writeback arbiter.
package regfile_wb_arbiter_pkg;
   localparam int XLEN = 32;
   localparam int AW = 5;
   localparam int NUM_REGS = 32;
   localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle: one valid/addr/data slot per source plus a grant.
interface regfile_wb_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int XLEN = regfile_wb_arbiter_pkg::XLEN,
   parameter int AW = regfile_wb_arbiter_pkg::AW
);
   logic [NUM_REQ-1:0]      req_valid_i;
   logic [AW*NUM_REQ-1:0]   req_addr_i;
   logic [XLEN*NUM_REQ-1:0] req_data_i;
   logic [NUM_REQ-1:0]      req_ready_o;

   modport master (
      output req_valid_i,
      output req_addr_i,
      output req_data_i,
      input  req_ready_o
   );

   modport slave (
      input  req_valid_i,
      input  req_addr_i,
      input  req_data_i,
      output req_ready_o
   );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin pick: first valid requester at or after ptr, wrapping upward.
module rr_arbiter #(
   parameter int N = 3,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  valid,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] idx
);
   int j;
   logic [PW-1:0] jj;

   // Scan from the far end so the nearest valid slot is written last.
   always_comb begin
      grant = '0;
      idx = '0;
      j = 0;
      jj = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % N;
         jj = PW'(j);
         if (valid[jj]) begin
            grant = '0;
            grant[jj] = 1'b1;
            idx = jj;
         end
      end
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among writeback sources and
// tracks destinations issued but not yet written back.
module regfile_wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int XLEN = regfile_wb_arbiter_pkg::XLEN,
   parameter int AW = regfile_wb_arbiter_pkg::AW
) (
   input  logic            clk_i,
   input  logic            reset,
   regfile_wb_arbiter_if.slave req,
   input  logic            issue_valid_i,
   input  logic [AW-1:0]   issue_rd_i,
   input  logic [AW-1:0]   rs_addr_i,
   input  logic [AW-1:0]   rt_addr_i,
   output logic            rs_busy_o,
   output logic            rt_busy_o,
   output logic            wr_en_o,
   output logic [AW-1:0]   wr_addr_o,
   output logic [XLEN-1:0] wr_data_o
);
   import regfile_wb_arbiter_pkg::*;

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PW-1:0]       rr_ptr;
   logic [PW-1:0]       gnt_idx;
   logic [NUM_REQ-1:0]  gnt;
   logic                xfer;
   logic [AW-1:0]       sel_addr;
   logic [XLEN-1:0]     sel_data;
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_nxt;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .valid (req.req_valid_i),
      .ptr   (rr_ptr),
      .grant (gnt),
      .idx   (gnt_idx)
   );

   assign req.req_ready_o = reset ? '0 : gnt;
   assign xfer = ~reset & (|req.req_valid_i);
   assign sel_addr = req.req_addr_i[AW*gnt_idx +: AW];
   assign sel_data = req.req_data_i[XLEN*gnt_idx +: XLEN];

   // x0 writes still handshake but never reach the register file.
   always_ff @(posedge clk_i) begin
      if (reset) begin
         rr_ptr <= '0;
         wr_en_o <= 1'b0;
         wr_addr_o <= '0;
         wr_data_o <= '0;
      end else begin
         wr_en_o <= xfer && (sel_addr != AW'(REG_ZERO));
         if (xfer) begin
            wr_addr_o <= sel_addr;
            wr_data_o <= sel_data;
            rr_ptr <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
         end
      end
   end

   // Issue is applied after the clear so a same-cycle set wins.
   always_comb begin
      busy_nxt = busy;
      if (wr_en_o)
         busy_nxt[wr_addr_o] = 1'b0;
      if (issue_valid_i && (issue_rd_i != AW'(REG_ZERO)))
         busy_nxt[issue_rd_i] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (reset)
         busy <= '0;
      else
         busy <= busy_nxt;
   end

   // Register file commits on the falling edge, so a clear in flight is visible.
   assign rs_busy_o = busy[rs_addr_i] & ~(wr_en_o & (wr_addr_o == rs_addr_i));
   assign rt_busy_o = busy[rt_addr_i] & ~(wr_en_o & (wr_addr_o == rt_addr_i));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized scoreboard bench for the writeback arbiter and busy scoreboard.
module tb_regfile_wb_arbiter;
   localparam int N = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic issue_valid_i;
   logic [4:0] issue_rd_i, rs_addr_i, rt_addr_i;
   logic rs_busy_o, rt_busy_o, wr_en_o;
   logic [4:0] wr_addr_o;
   logic [31:0] wr_data_o;

   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.NUM_REQ(N), .XLEN(32), .AW(5)) rif ();

   regfile_wb_arbiter #(.NUM_REQ(N), .XLEN(32), .AW(5)) dut (
      .clk_i         (clk),
      .reset         (reset),
      .req           (rif),
      .issue_valid_i (issue_valid_i),
      .issue_rd_i    (issue_rd_i),
      .rs_addr_i     (rs_addr_i),
      .rt_addr_i     (rt_addr_i),
      .rs_busy_o     (rs_busy_o),
      .rt_busy_o     (rt_busy_o),
      .wr_en_o       (wr_en_o),
      .wr_addr_o     (wr_addr_o),
      .wr_data_o     (wr_data_o)
   );

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
      int          due;
   } wr_t;

   wr_t exp_q[$];
   int vec = 0;
   int errs = 0;
   int cyc = 0;
   bit mon_on = 1'b0;

   bit pend[N];
   logic [4:0] paddr[N];
   logic [31:0] pdata[N];
   int ptr = 0;
   bit mbusy[32];
   bit last_wr = 1'b0;
   logic [4:0] last_addr = '0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
      vec++;
      if (act !== expv) begin
         errs++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, expv);
      end
   endtask

   task automatic post(int i, logic [4:0] a, logic [31:0] d);
      pend[i] = 1'b1;
      paddr[i] = a;
      pdata[i] = d;
   endtask

   task automatic step(bit rst, bit iv, logic [4:0] ird,
                       logic [4:0] qs, logic [4:0] qt);
      int g;
      bit cw;
      logic [4:0] ca;
      logic [N-1:0] expr;
      @(posedge clk);
      cyc++;
      #1;
      reset = rst;
      for (int i = 0; i < N; i++) begin
         rif.req_valid_i[i] = pend[i];
         rif.req_addr_i[5*i +: 5] = paddr[i];
         rif.req_data_i[32*i +: 32] = pdata[i];
      end
      issue_valid_i = iv;
      issue_rd_i = ird;
      rs_addr_i = qs;
      rt_addr_i = qt;
      #2;
      g = -1;
      if (!rst)
         for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (g < 0 && pend[j]) g = j;
         end
      expr = '0;
      if (g >= 0) expr[g] = 1'b1;
      chk("ready", rif.req_ready_o, expr);
      chk("rs_busy", rs_busy_o, mbusy[qs] && !(last_wr && last_addr == qs));
      chk("rt_busy", rt_busy_o, mbusy[qt] && !(last_wr && last_addr == qt));
      cw = last_wr;
      ca = last_addr;
      if (rst) begin
         ptr = 0;
         for (int r = 0; r < 32; r++) mbusy[r] = 1'b0;
         last_wr = 1'b0;
      end else begin
         if (cw) mbusy[ca] = 1'b0;
         if (iv && ird != 5'd0) mbusy[ird] = 1'b1;
         last_wr = 1'b0;
         if (g >= 0) begin
            pend[g] = 1'b0;
            ptr = (g + 1) % N;
            if (paddr[g] != 5'd0) begin
               last_wr = 1'b1;
               last_addr = paddr[g];
               exp_q.push_back('{paddr[g], pdata[g], cyc + 1});
            end
         end
      end
   endtask

   task automatic idle(logic [4:0] qs, logic [4:0] qt);
      step(1'b0, 1'b0, 5'd0, qs, qt);
   endtask

   // Write-port monitor: each cycle's write must match the oldest expected one.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_on) begin
            bit due;
            wr_t e;
            due = exp_q.size() > 0 && exp_q[0].due == cyc;
            chk("wr_en", wr_en_o, due);
            if (due) begin
               e = exp_q.pop_front();
               if (wr_en_o === 1'b1) begin
                  chk("wr_addr", wr_addr_o, e.a);
                  chk("wr_data", wr_data_o, e.d);
               end
            end
         end
      end
   end

   initial begin
      rif.req_valid_i = '0;
      rif.req_addr_i = '0;
      rif.req_data_i = '0;
      issue_valid_i = 1'b0;
      issue_rd_i = '0;
      rs_addr_i = '0;
      rt_addr_i = '0;
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0;
         paddr[i] = '0;
         pdata[i] = '0;
      end
      for (int r = 0; r < 32; r++) mbusy[r] = 1'b0;

      step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
      mon_on = 1'b1;
      step(1'b1, 1'b0, 5'd0, 5'd1, 5'd2);
      chk("rst_wr_en", wr_en_o, 0);
      chk("rst_wr_addr", wr_addr_o, 0);
      chk("rst_wr_data", wr_data_o, 0);

      // All three sources contend continuously.
      for (int n = 0; n < 6; n++) begin
         for (int i = 0; i < N; i++)
            if (!pend[i]) post(i, 5'(10 + i + 3 * n), $urandom);
         idle(5'd0, 5'd0);
      end
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      idle(5'd0, 5'd0);
      idle(5'd0, 5'd0);

      post(1, 5'd5, 32'hDEADBEEF);
      idle(5'd5, 5'd0);
      idle(5'd5, 5'd0);
      idle(5'd5, 5'd0);

      post(2, 5'd0, 32'h12345678);
      step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
      idle(5'd0, 5'd0);

      step(1'b0, 1'b1, 5'd7, 5'd7, 5'd7);
      idle(5'd7, 5'd0);
      post(0, 5'd7, 32'hA5A5_0007);
      idle(5'd7, 5'd7);
      idle(5'd7, 5'd7);
      idle(5'd7, 5'd7);

      step(1'b0, 1'b1, 5'd9, 5'd9, 5'd0);
      post(2, 5'd9, 32'h0000_0999);
      idle(5'd9, 5'd9);
      step(1'b0, 1'b1, 5'd9, 5'd9, 5'd9);
      idle(5'd9, 5'd9);

      for (int i = 0; i < N; i++) post(i, 5'(20 + i), $urandom);
      step(1'b0, 1'b1, 5'd3, 5'd3, 5'd4);
      step(1'b0, 1'b1, 5'd4, 5'd3, 5'd4);
      step(1'b1, 1'b0, 5'd0, 5'd3, 5'd4);
      idle(5'd3, 5'd4);
      idle(5'd3, 5'd4);

      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < N; i++)
            if (!pend[i] && $urandom_range(0, 2) == 0)
               post(i, 5'($urandom_range(0, 15)), $urandom);
         step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
              5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
              5'($urandom_range(0, 15)));
      end

      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      idle(5'd0, 5'd0);
      idle(5'd0, 5'd0);
      idle(5'd0, 5'd0);
      chk("queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
